// File: rtl/core_pkg.sv
// Shared definitions for the RV32 pipeline.
// Holds the datapath width, control bundle layout and bubble constant.
package core_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 8;

    localparam int CTRL_REGWRITE  = 0;
    localparam int CTRL_MEMREAD   = 1;
    localparam int CTRL_MEMWRITE  = 2;
    localparam int CTRL_MEMTOREG  = 3;
    localparam int CTRL_BRANCH    = 4;
    localparam int CTRL_ALUSRC    = 5;
    localparam int CTRL_ALUOP_LSB = 6;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detector between the EX-side load and the decode slot.
// Purely combinational so it can be replicated per issue path.
import core_pkg::*;

module load_use_detect (
    input  logic       ex_valid,
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    output logic       lu
);

    logic rd_nz;
    logic rd_hit;

    // A load writing a non-zero rd that decode reads through either source.
    always_comb begin
        rd_nz  = (ex_rd != 5'd0);
        rd_hit = (ex_rd == id_rs1) | (ex_rd == id_rs2);
        lu     = ex_valid & ex_memread & rd_nz & id_valid & rd_hit;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush and hold.
// Optional event counters are built when ID_EX_STALL_CNT_EN is defined.
import core_pkg::*;

module id_ex_stage #(
    parameter int XW = core_pkg::XLEN,
    parameter int CW = core_pkg::CTRL_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold,
    input  logic          flush,
    input  logic          if_id_valid,
    input  logic [4:0]    if_id_rs1,
    input  logic [4:0]    if_id_rs2,
    input  logic [4:0]    if_id_rd,
    input  logic [XW-1:0] if_id_rdata1,
    input  logic [XW-1:0] if_id_rdata2,
    input  logic [XW-1:0] if_id_imm,
    input  logic [XW-1:0] if_id_pc,
    input  logic [CW-1:0] if_id_ctrl,
    output logic          stall,
`ifdef ID_EX_STALL_CNT_EN
    output logic [31:0]   stall_cnt,
    output logic [31:0]   flush_cnt,
`endif
    output logic          id_ex_valid,
    output logic [4:0]    id_ex_rs1,
    output logic [4:0]    id_ex_rs2,
    output logic [4:0]    id_ex_rd,
    output logic [XW-1:0] id_ex_rdata1,
    output logic [XW-1:0] id_ex_rdata2,
    output logic [XW-1:0] id_ex_imm,
    output logic [XW-1:0] id_ex_pc,
    output logic [CW-1:0] id_ex_ctrl
);

    logic lu;
    logic bubble;

    load_use_detect u_lud (
        .ex_valid   (id_ex_valid),
        .ex_memread (id_ex_ctrl[CTRL_MEMREAD]),
        .ex_rd      (id_ex_rd),
        .id_valid   (if_id_valid),
        .id_rs1     (if_id_rs1),
        .id_rs2     (if_id_rs2),
        .lu         (lu)
    );

    // Flush overrides the stall; the decode slot is discarded upstream.
    always_comb begin
        stall  = lu & ~flush & ~rst;
        bubble = flush | lu;
    end

    // Pipeline register: reset, then flush, then hold, then bubble/load.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_valid  <= 1'b0;
            id_ex_rs1    <= '0;
            id_ex_rs2    <= '0;
            id_ex_rd     <= '0;
            id_ex_rdata1 <= '0;
            id_ex_rdata2 <= '0;
            id_ex_imm    <= '0;
            id_ex_pc     <= '0;
            id_ex_ctrl   <= CTRL_BUBBLE;
        end else if (flush || !hold) begin
            id_ex_rs1    <= if_id_rs1;
            id_ex_rs2    <= if_id_rs2;
            id_ex_rdata1 <= if_id_rdata1;
            id_ex_rdata2 <= if_id_rdata2;
            id_ex_imm    <= if_id_imm;
            id_ex_pc     <= if_id_pc;
            if (bubble) begin
                id_ex_valid <= 1'b0;
                id_ex_rd    <= '0;
                id_ex_ctrl  <= CTRL_BUBBLE;
            end else begin
                id_ex_valid <= if_id_valid;
                id_ex_rd    <= if_id_rd;
                id_ex_ctrl  <= if_id_valid ? if_id_ctrl : CTRL_BUBBLE;
            end
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    // Count applied flushes and inserted load-use bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (flush) begin
            flush_cnt <= flush_cnt + 32'd1;
        end else if (!hold && lu) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with a behavioural reference model.
// Counter checks are included when ID_EX_STALL_CNT_EN is defined.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, hold, flush, if_id_valid;
    logic [4:0]  if_id_rs1, if_id_rs2, if_id_rd;
    logic [31:0] if_id_rdata1, if_id_rdata2, if_id_imm, if_id_pc;
    logic [7:0]  if_id_ctrl;
    logic        stall, id_ex_valid;
    logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
    logic [31:0] id_ex_rdata1, id_ex_rdata2, id_ex_imm, id_ex_pc;
    logic [7:0]  id_ex_ctrl;
`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state: what EX must see after each edge.
    logic        m_valid;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [31:0] m_d1, m_d2, m_imm, m_pc;
    logic [7:0]  m_ctrl;
    int          m_scnt, m_fcnt;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk          (clk),
        .rst          (rst),
        .hold         (hold),
        .flush        (flush),
        .if_id_valid  (if_id_valid),
        .if_id_rs1    (if_id_rs1),
        .if_id_rs2    (if_id_rs2),
        .if_id_rd     (if_id_rd),
        .if_id_rdata1 (if_id_rdata1),
        .if_id_rdata2 (if_id_rdata2),
        .if_id_imm    (if_id_imm),
        .if_id_pc     (if_id_pc),
        .if_id_ctrl   (if_id_ctrl),
        .stall        (stall),
`ifdef ID_EX_STALL_CNT_EN
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
`endif
        .id_ex_valid  (id_ex_valid),
        .id_ex_rs1    (id_ex_rs1),
        .id_ex_rs2    (id_ex_rs2),
        .id_ex_rd     (id_ex_rd),
        .id_ex_rdata1 (id_ex_rdata1),
        .id_ex_rdata2 (id_ex_rdata2),
        .id_ex_imm    (id_ex_imm),
        .id_ex_pc     (id_ex_pc),
        .id_ex_ctrl   (id_ex_ctrl)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare every registered output against the model.
    task automatic compare_regs();
        chk("valid", 32'(id_ex_valid), 32'(m_valid));
        chk("rs1", 32'(id_ex_rs1), 32'(m_rs1));
        chk("rs2", 32'(id_ex_rs2), 32'(m_rs2));
        chk("rd", 32'(id_ex_rd), 32'(m_rd));
        chk("rdata1", id_ex_rdata1, m_d1);
        chk("rdata2", id_ex_rdata2, m_d2);
        chk("imm", id_ex_imm, m_imm);
        chk("pc", id_ex_pc, m_pc);
        chk("ctrl", 32'(id_ex_ctrl), 32'(m_ctrl));
`ifdef ID_EX_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, 32'(m_scnt));
        chk("flush_cnt", flush_cnt, 32'(m_fcnt));
`endif
    endtask

    function automatic logic model_lu();
        return m_valid && m_ctrl[1] && (m_rd != 5'd0) && if_id_valid &&
               ((m_rd == if_id_rs1) || (m_rd == if_id_rs2));
    endfunction

    // One cycle: drive at negedge, check stall, advance model, check regs.
    task automatic cyc(input logic r, input logic h, input logic f,
                       input logic v, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [4:0] d,
                       input logic [7:0] c);
        logic lu;
        logic exp_stall;
        @(negedge clk);
        rst = r; hold = h; flush = f; if_id_valid = v;
        if_id_rs1 = s1; if_id_rs2 = s2; if_id_rd = d; if_id_ctrl = c;
        if_id_rdata1 = $urandom; if_id_rdata2 = $urandom;
        if_id_imm = $urandom; if_id_pc = $urandom;
        #1;
        lu = model_lu();
        exp_stall = lu && !f && !r;
        chk("stall", 32'(stall), 32'(exp_stall));
        if (r) begin
            {m_valid, m_rs1, m_rs2, m_rd, m_ctrl} = '0;
            {m_d1, m_d2, m_imm, m_pc} = '0;
            m_scnt = 0; m_fcnt = 0;
        end else if (f || (!h)) begin
            m_rs1 = s1; m_rs2 = s2;
            m_d1 = if_id_rdata1; m_d2 = if_id_rdata2;
            m_imm = if_id_imm; m_pc = if_id_pc;
            if (f || lu) begin
                m_valid = 1'b0; m_rd = 5'd0; m_ctrl = 8'h00;
                if (f) m_fcnt++;
                else m_scnt++;
            end else begin
                m_valid = v; m_rd = d;
                m_ctrl = v ? c : 8'h00;
            end
        end
        @(posedge clk);
        #1;
        compare_regs();
    endtask

    localparam logic [7:0] LW  = 8'h0B;
    localparam logic [7:0] ADD = 8'h81;

    initial begin
        // Reset with nonzero inputs for two cycles.
        cyc(1, 0, 0, 1, 5'd3, 5'd4, 5'd5, LW);
        cyc(1, 1, 1, 1, 5'd3, 5'd4, 5'd5, LW);
        chk("rst_valid_lit", 32'(id_ex_valid), 32'd0);
        chk("rst_ctrl_lit", 32'(id_ex_ctrl), 32'd0);

        // Release: lw x5 loads, then add x6,x5,x7 stalls once.
        cyc(0, 0, 0, 1, 5'd1, 5'd2, 5'd5, LW);
        chk("lw_rd_lit", 32'(id_ex_rd), 32'd5);
        cyc(0, 0, 0, 1, 5'd5, 5'd7, 5'd6, ADD);
        chk("lu_bubble_valid_lit", 32'(id_ex_valid), 32'd0);
        chk("lu_bubble_ctrl_lit", 32'(id_ex_ctrl), 32'd0);
        cyc(0, 0, 0, 1, 5'd5, 5'd7, 5'd6, ADD);
        chk("lu_release_rs1_lit", 32'(id_ex_rs1), 32'd5);
        chk("lu_release_stall_lit", 32'(stall), 32'd0);

        // lw x0 never stalls; a non-load producer never stalls.
        cyc(0, 0, 0, 1, 5'd1, 5'd2, 5'd0, LW);
        cyc(0, 0, 0, 1, 5'd0, 5'd0, 5'd9, ADD);
        cyc(0, 0, 0, 1, 5'd1, 5'd2, 5'd5, ADD);
        cyc(0, 0, 0, 1, 5'd8, 5'd5, 5'd10, ADD);
        chk("nonload_rd_lit", 32'(id_ex_rd), 32'd10);

        // Flush beats lu and hold together.
        cyc(0, 0, 0, 1, 5'd1, 5'd2, 5'd5, LW);
        cyc(0, 1, 1, 1, 5'd5, 5'd7, 5'd6, ADD);
        chk("flush_valid_lit", 32'(id_ex_valid), 32'd0);

        // Hold three cycles with changing inputs, then release.
        cyc(0, 0, 0, 1, 5'd11, 5'd12, 5'd13, ADD);
        cyc(0, 1, 0, 1, 5'd14, 5'd15, 5'd16, LW);
        cyc(0, 1, 0, 0, 5'd17, 5'd18, 5'd19, ADD);
        cyc(0, 1, 0, 1, 5'd20, 5'd21, 5'd22, ADD);
        chk("hold_rd_lit", 32'(id_ex_rd), 32'd13);
        cyc(0, 0, 0, 1, 5'd23, 5'd24, 5'd25, ADD);

        // Invalid decode slot forces ctrl to zero.
        cyc(0, 0, 0, 0, 5'd1, 5'd2, 5'd3, 8'hFF);
        chk("invalid_ctrl_lit", 32'(id_ex_ctrl), 32'd0);

        // Load-use under hold: stall stays high, no bubble until release.
        cyc(0, 0, 0, 1, 5'd1, 5'd2, 5'd7, LW);
        cyc(0, 1, 0, 1, 5'd3, 5'd7, 5'd8, ADD);
        cyc(0, 1, 0, 1, 5'd3, 5'd7, 5'd8, ADD);
        cyc(0, 0, 0, 1, 5'd3, 5'd7, 5'd8, ADD);
        cyc(0, 0, 0, 1, 5'd3, 5'd7, 5'd8, ADD);

        // More load-use events and a flush.
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 1, 5'd1, 5'd2, 5'd9, LW);
            cyc(0, 0, 0, 1, 5'd9, 5'd2, 5'd4, ADD);
            cyc(0, 0, 0, 1, 5'd9, 5'd2, 5'd4, ADD);
        end
        cyc(0, 0, 1, 1, 5'd1, 5'd2, 5'd3, ADD);
`ifdef ID_EX_STALL_CNT_EN
        chk("stall_cnt_lit", stall_cnt, 32'd4);
        chk("flush_cnt_lit", flush_cnt, 32'd2);
`endif

        // Reset mid-stall clears the bubble and the stall.
        cyc(0, 0, 0, 1, 5'd1, 5'd2, 5'd6, LW);
        cyc(1, 0, 0, 1, 5'd6, 5'd2, 5'd4, ADD);
        cyc(0, 0, 0, 1, 5'd6, 5'd2, 5'd4, ADD);
        chk("post_rst_valid_lit", 32'(id_ex_valid), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage RV32 core, sitting between the decode stage and the execute stage.
- Captures decoded operands, register indices, immediate, PC and control bundle each cycle.
- Detects load-use hazards and generates the stall request together with bubble insertion.
- Handles branch flush and external hold.
- Its registered rs1/rs2/rd/RegWrite outputs are the EX-side inputs consumed by the forwarding unit.

Parameters:
- XLEN, 32, datapath width of operands, immediate and PC.
- CTRL_W, 8, control bundle width. Bit map: [0] RegWrite, [1] MemRead, [2] MemWrite, [3] MemtoReg, [4] Branch, [5] ALUSrc, [7:6] ALUOp.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous reset, active high.
- hold  in  1  freeze request from the memory stage; all state is held.
- flush  in  1  branch/jump taken in EX; kills the instruction entering ID/EX.
- if_id_valid  in  1  decode slot holds a real instruction.
- if_id_rs1, if_id_rs2, if_id_rd  in  5 each  decoded register indices.
- if_id_rdata1, if_id_rdata2  in  XLEN each  register-file read data.
- if_id_imm, if_id_pc  in  XLEN each  immediate, PC.
- if_id_ctrl  in  CTRL_W  decoded control bundle.
- stall  out  1  combinational; stalls PC and IF/ID (write-enable low).
- id_ex_valid  out  1  registered.
- id_ex_rs1, id_ex_rs2, id_ex_rd  out  5 each  registered.
- id_ex_rdata1, id_ex_rdata2, id_ex_imm, id_ex_pc  out  XLEN each  registered.
- id_ex_ctrl  out  CTRL_W  registered.

Behaviour:
- Reset: every registered output is 0, including id_ex_valid and id_ex_ctrl. stall reads 0 while rst is high.
- Load-use detection (combinational):
  - lu = id_ex_valid & id_ex_ctrl[1] & (id_ex_rd != 0) & if_id_valid & ((id_ex_rd == if_id_rs1) | (id_ex_rd == if_id_rs2)).
  - stall = lu & ~flush & ~rst.
- Update priority at each rising edge, highest first:
  1. rst: clear all.
  2. flush: bubble (valid=0, ctrl=0, rd=0; other fields don't-care but are loaded from IF/ID). Flush is never lost to hold.
  3. hold: all registers keep their value.
  4. lu: bubble, same as flush.
  5. Otherwise: load all IF/ID fields. id_ex_valid = if_id_valid. ctrl is forced to 0 when if_id_valid = 0.
- Latency: 1 cycle from IF/ID inputs to id_ex_* outputs.
- Stall duration:
  - A single load-use produces exactly one bubble. The bubble has MemRead=0, so lu deasserts the next cycle and the held instruction enters.
  - If hold is active, stall may stay high across multiple cycles. It is the same condition re-evaluated each cycle; no extra bubbles are inserted because hold blocks state updates.
- rs1/rs2 comparison ignores whether the instruction actually uses rs2. A false stall is acceptable and is not a correctness issue.
- rd = x0 never causes a stall.
- Simultaneous flush and lu: flush wins and stall = 0. The faulting decode instruction is discarded by upstream flush.
- Reset mid-stall: bubble state is cleared and no stall is remembered.

Optional Feature:
- Macro: ID_EX_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt [31:0] and output flush_cnt [31:0].
  - stall_cnt increments on each edge where a load-use bubble is inserted (priority item 4).
  - flush_cnt increments on each edge where flush is applied.
  - Both cleared by rst; both wrap at 2^32; neither increments under hold (flush still counts).
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package (core_pkg) holds:
  - XLEN default.
  - CTRL_W.
  - Control bit index constants: CTRL_REGWRITE=0, CTRL_MEMREAD=1, CTRL_MEMWRITE=2, CTRL_MEMTOREG=3, CTRL_BRANCH=4, CTRL_ALUSRC=5, CTRL_ALUOP_LSB=6.
  - A CTRL_BUBBLE zero constant.
- One natural sub-module, load_use_detect: purely combinational lu computation. It is reused if a second issue path is added.

Test Plan:
- Reset: hold rst=1 for 2 cycles with nonzero inputs -> all id_ex_* = 0, stall = 0. Release -> the next edge loads inputs.
- Load-use: lw x5 in ID/EX (ctrl MemRead=1, rd=5), decode add x6,x5,x7 (rs1=5) -> stall=1 that cycle, next id_ex_valid=0 and ctrl=0. Following edge: id_ex_rs1=5, stall=0.
- x0 / non-load:
  - lw x0 in ID/EX with decode rs1=0 -> stall=0.
  - add x5 (MemRead=0) in ID/EX with decode rs2=5 -> stall=0 and normal load.
- Flush priority: flush=1 together with lu=1 and hold=1 -> stall=0, next edge id_ex_valid=0, ctrl=0.
- Hold: hold=1 for 3 cycles with changing IF/ID -> id_ex_* unchanged. After release, the next edge loads the current inputs. Under ID_EX_STALL_CNT_EN, stall_cnt is unchanged during hold.
- Counters (ID_EX_STALL_CNT_EN): 4 load-use events and 2 flushes -> stall_cnt=4, flush_cnt=2. rst -> both 0.
